slice_write_scheduler: RTL

Shares one packed word-array register file between NREQ requesters. Each requester writes a SLICE_W-bit field at a signed bit offset in one word, using either ascending (+:) or descending (-:) indexed part-select semantics.
- Round-robin arbitration picks one requester per cycle.
- A one-deep commit stage applies the granted write.
- Out-of-range bits are clipped and out-of-range word indices are dropped, with a status pulse for each case.
- Sits between register-update sources and any consumer that reads the array.

---
 rtl/slice_sched_pkg.sv | 63 ++++++
 rtl/slice_rr_arbiter.sv | 58 +++++
 rtl/slice_write_scheduler.sv | 116 +++++++++++
 3 files changed

// File: rtl/slice_sched_pkg.sv
// Shared types and slice-placement helper for the slice write scheduler.
// The placement function is elaborated at the field geometry fixed here;
// the top-level WORD_W / SLICE_W / OFF_W parameters default to these values.
package slice_sched_pkg;

  localparam int SS_WORD_W    = 32;
  localparam int SS_SLICE_W   = 8;
  localparam int SS_OFF_W     = 7;
  // Widest word index a request record can carry; the top zero-extends.
  localparam int SS_IDX_MAX_W = 8;

  // Position arithmetic is wide enough that off +/- SLICE_W never wraps.
  localparam int SS_POS_W = SS_OFF_W + $clog2(SS_SLICE_W) + 1;
  localparam int SS_BIT_W = $clog2(SS_WORD_W);

  localparam logic signed [SS_POS_W-1:0] SS_POS_LIMIT    = SS_POS_W'(SS_WORD_W);
  localparam logic signed [SS_POS_W-1:0] SS_POS_DOWN_ADJ = SS_POS_W'(1 - SS_SLICE_W);

  typedef enum logic {
    DIR_UP   = 1'b0,  // data bit k lands at off + k
    DIR_DOWN = 1'b1   // data bit k lands at off - SLICE_W + 1 + k
  } dir_e;

  typedef struct packed {
    logic [SS_IDX_MAX_W-1:0] word;
    logic [SS_OFF_W-1:0]     off;
    dir_e                    dir;
    logic [SS_SLICE_W-1:0]   data;
  } slice_req_t;

  typedef struct packed {
    logic [SS_WORD_W-1:0] mask;  // bits of the word that this write changes
    logic [SS_WORD_W-1:0] data;  // slice data already moved to its positions
    logic                 clip;  // at least one slice bit fell outside the word
  } slice_place_t;

  // Map a slice onto word positions, dropping bits outside [0, WORD_W-1].
  function automatic slice_place_t slice_mask_and_data(
    input logic [SS_OFF_W-1:0]   off,
    input dir_e                  dir,
    input logic [SS_SLICE_W-1:0] data
  );
    slice_place_t             r;
    logic signed [SS_POS_W-1:0] base;
    logic signed [SS_POS_W-1:0] pos;
    r    = '0;
    base = {{(SS_POS_W - SS_OFF_W){off[SS_OFF_W-1]}}, off};
    if (dir == DIR_DOWN) begin
      base = base + SS_POS_DOWN_ADJ;
    end
    for (int k = 0; k < SS_SLICE_W; k++) begin
      pos = base + SS_POS_W'(k);
      if (!pos[SS_POS_W-1] && (pos < SS_POS_LIMIT)) begin
        r.mask[pos[SS_BIT_W-1:0]] = 1'b1;
        r.data[pos[SS_BIT_W-1:0]] = data[k];
      end else begin
        r.clip = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/slice_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, priority starting at the
// pointer and wrapping; the pointer moves past the winner on advance.
module slice_rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  valid_i,
  input  logic             advance_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [SEL_W-1:0] grant_idx_o
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic             found;

  function automatic int wrap_idx(input int v);
    return (v >= NREQ) ? (v - NREQ) : v;
  endfunction

  // Pick the first valid requester at or after the pointer.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int o = 0; o < NREQ; o++) begin
      if (!found && valid_i[wrap_idx(int'(ptr_q) + o)]) begin
        found                                = 1'b1;
        grant_o[wrap_idx(int'(ptr_q) + o)]   = 1'b1;
        grant_idx_o                          = SEL_W'(wrap_idx(int'(ptr_q) + o));
      end
    end
  end

  // Next pointer: one past the winner on an accepted grant, else hold.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_idx_o == SEL_W'(NREQ - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  // Pointer register with synchronous reset to requester 0.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/slice_write_scheduler.sv
// Shared word-array register file: round-robin granted slice writes pass
// through a one-deep commit stage, are clipped to the word and merged in.
module slice_write_scheduler
  import slice_sched_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int NWORDS  = 2,
  parameter  int WORD_W  = SS_WORD_W,
  parameter  int SLICE_W = SS_SLICE_W,
  parameter  int OFF_W   = SS_OFF_W,
  localparam int IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ-1:0][IDX_W-1:0]      req_word,
  input  logic [NREQ-1:0][OFF_W-1:0]      req_off,
  input  logic [NREQ-1:0]                 req_dir,
  input  logic [NREQ-1:0][SLICE_W-1:0]    req_data,
  output logic [NWORDS-1:0][WORD_W-1:0]   mem_q,
  output logic                            busy,
  output logic                            clipped,
  output logic                            err_drop
);

  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  valid_gated;
  logic [NREQ-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic             accept;

  slice_req_t   sel_req;
  slice_req_t   stage_q;
  slice_req_t   stage_d;
  logic         stage_valid_q;
  logic         stage_valid_d;
  slice_place_t place;
  logic         word_ok;
  logic         clipped_q;
  logic         err_drop_q;

  // Nothing is granted while reset is asserted.
  assign valid_gated = rst_n ? req_valid : '0;

  slice_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_gated),
    .advance_i   (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Select the granted request and decide what the commit stage loads.
  always_comb begin
    sel_req       = '0;
    sel_req.word  = SS_IDX_MAX_W'(req_word[grant_idx]);
    sel_req.off   = req_off[grant_idx];
    sel_req.dir   = dir_e'(req_dir[grant_idx]);
    sel_req.data  = req_data[grant_idx];
    stage_valid_d = accept;
    stage_d       = accept ? sel_req : stage_q;
  end

  // Commit stage: holds exactly one accepted write for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_q       <= stage_d;
    end
  end

  assign place   = slice_mask_and_data(stage_q.off, stage_q.dir, stage_q.data);
  assign word_ok = (stage_q.word < SS_IDX_MAX_W'(NWORDS));

  // Apply the staged write to its word and raise the status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the array itself is cleared on reset because consumers read
      // it directly and must see a defined all-zero image afterwards.
      mem_q      <= '0;
      clipped_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      clipped_q  <= 1'b0;
      err_drop_q <= 1'b0;
      if (stage_valid_q) begin
        if (word_ok) begin
          clipped_q <= place.clip;
          for (int w = 0; w < NWORDS; w++) begin
            if (stage_q.word == SS_IDX_MAX_W'(w)) begin
              mem_q[w] <= (mem_q[w] & ~place.mask) | (place.data & place.mask);
            end
          end
        end else begin
          err_drop_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = stage_valid_q;
  assign clipped  = clipped_q;
  assign err_drop = err_drop_q;

endmodule
